// File: rtl/bit_serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_addsub_pkg
// Description : Shared state encodings and default width for the bit-serial
//               add/subtract unit.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int c_default_width = 8;

endpackage : bit_serial_addsub_pkg
`default_nettype wire

// File: rtl/bit_serial_addsub_fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : serial_fa_cell
// Description : Combinational 1-bit full adder used as the serial bit cell.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : serial_fa_cell
`default_nettype wire

// File: rtl/bit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_addsub
// Description : LSB-first bit-serial add/subtract over WIDTH-bit operands
//               with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_addsub
    import bit_serial_addsub_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int                  c_cw      = $clog2(WIDTH);
    localparam logic [c_cw-1:0]     c_last    = c_cw'(WIDTH - 1);
    localparam logic [c_cw-1:0]     c_msb_cnt = c_cw'(WIDTH - 2);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic [c_cw-1:0]    r_count;
    logic               r_carry;
    logic               r_c_msb_in;
    logic               r_cout;
    logic               r_overflow;
    logic               w_sum;
    logic               w_carry_nxt;
    logic [WIDTH-1:0]   w_acc_shift;

    serial_fa_cell u_fa_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_carry_nxt)
    );

    // Partial sum with the new bit at the MSB; on the last bit this is the full result.
    assign w_acc_shift = {w_sum, r_acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_count == c_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_count    <= '0;
            r_carry    <= 1'b0;
            r_c_msb_in <= 1'b0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1; the +1 rides in as the initial carry.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_count <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_shift[WIDTH-1:1];
                    r_carry <= w_carry_nxt;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_count <= r_count + c_cw'(1);
                    if (r_count == c_msb_cnt) begin
                        r_c_msb_in <= w_carry_nxt;
                    end
                    if (r_count == c_last) begin
                        r_result   <= w_acc_shift;
                        r_cout     <= w_carry_nxt;
                        r_overflow <= r_c_msb_in ^ w_carry_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule : bit_serial_addsub
`default_nettype wire

// File: tb/tb_bit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serial_addsub
// Description : Directed self-checking bench for bit_serial_addsub (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_addsub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    int n_checks = 0;
    int n_pass   = 0;

    bit_serial_addsub #(.WIDTH(WIDTH)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation: start for a single cycle, scramble inputs afterwards,
    // then wait (bounded) for done and compare latency and outputs.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                          input logic [7:0] er, input logic ec, input logic eo,
                          input string tag);
        int n;
        @(posedge clk); #1;
        start = 1'b1; a = ta; b = tb; sub = ts;
        @(posedge clk); #1;
        start = 1'b0; a = ~ta; b = 8'h5A; sub = ~ts;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        // done is first seen 8 edges after the accepting edge (9th cycle from it).
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [7:0] fa_of(input int k);
        return 8'((k * 7 + 3) & 255);
    endfunction

    function automatic logic [7:0] fb_of(input int k);
        return 8'((k * 13 + 50) & 255);
    endfunction

    initial begin
        int n_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        run_op(8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, "add");
        run_op(8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0, "wrap");
        run_op(8'd5, 8'd7, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_borrow");
        run_op(8'd7, 8'd5, 1'b1, 8'd2, 1'b1, 1'b0, "sub_pos");
        run_op(8'd127, 8'd1, 1'b0, 8'd128, 1'b0, 1'b1, "ovf_add");
        run_op(8'd128, 8'd1, 1'b1, 8'd127, 1'b1, 1'b1, "ovf_sub");

        // Back-to-back: start held, operands change every cycle.
        n_done = 0;
        @(posedge clk); #1;
        start = 1'b1; sub = 1'b0;
        for (int k = 0; k < 30; k++) begin
            a = fa_of(k);
            b = fb_of(k);
            @(posedge clk); #1;
            if (done) n_done++;
            check($sformatf("stream_done_k%0d", k), 32'(done), 32'((k % 10) == 8));
            if ((k % 10) == 8) begin
                check($sformatf("stream_result_k%0d", k), 32'(result),
                      32'(8'(fa_of(k - 8) + fb_of(k - 8))));
            end
        end
        start = 1'b0;
        check("stream_pulses", 32'(n_done), 32'd3);
        // Last accept at k=20 finished at k=28; the DONE->IDLE edge is k=29.
        @(posedge clk); #1;

        // Abort mid-run: outputs currently hold a non-zero result.
        @(posedge clk); #1;
        start = 1'b1; a = 8'd200; b = 8'd100; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        run_op(8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, "post_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bit_serial_addsub
`default_nettype wire
